// File: rtl/cpu_thread_switch_pkg.sv
// Shared types and defaults for the hardware thread scheduler.
// Optional feature macro: CPU_THREAD_TIMESLICE_EN (forced switch after TIMESLICE RUN cycles).
package cpu_thread_switch_pkg;

    localparam int CPU_TS_N_THREADS = 4;
    localparam int CPU_TS_TIMESLICE = 64;

    typedef enum logic [2:0] {
        CPU_TS_IDLE,
        CPU_TS_SELECT,
        CPU_TS_LOAD,
        CPU_TS_RUN,
        CPU_TS_SAVE
    } cpu_ts_state_t;

    // Width of a thread index; at least one bit.
    function automatic int cpu_ts_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_thread_switch_rr_select.sv
// Combinational round-robin finder: first ready bit at or after start, wrapping at N.
// Shared with the unit arbiters; start must be below N.
module cpu_thread_switch_rr_select
    import cpu_thread_switch_pkg::*;
#(
    parameter int N = CPU_TS_N_THREADS,
    parameter int W = cpu_ts_idx_w(N)
) (
    input  logic [N-1:0] ready,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);

    int           k;
    logic [W-1:0] kk;

    // Scan N candidates from start; the wrap is modulo N, not 2**W.
    always_comb begin
        found = 1'b0;
        index = '0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) begin
                k = k - N;
            end
            kk = W'(k);
            if (!found && ready[kk]) begin
                found = 1'b1;
                index = kk;
            end
        end
    end

endmodule

// File: rtl/cpu_thread_switch.sv
// Thread scheduler: round-robin pick, save outgoing context, load incoming, run.
// Optional: define CPU_THREAD_TIMESLICE_EN to force a switch every TIMESLICE RUN cycles.
module cpu_thread_switch
    import cpu_thread_switch_pkg::*;
#(
    parameter int N_THREADS = CPU_TS_N_THREADS,
    localparam int N_THREADS_MSB = cpu_ts_idx_w(N_THREADS) - 1
`ifdef CPU_THREAD_TIMESLICE_EN
    ,
    parameter int TIMESLICE = CPU_TS_TIMESLICE
`endif
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_THREADS-1:0]   thread_ready,
    input  logic                   switch_req,
    output logic [N_THREADS_MSB:0] thread_num,
    output logic                   load_en,
    output logic                   save_en,
    output logic                   run,
    output logic                   switch_done
);

    localparam int W = N_THREADS_MSB + 1;
    localparam logic [W-1:0] LAST_IDX = W'(N_THREADS - 1);

    cpu_ts_state_t state;
    logic [W-1:0]  last;
    logic [W-1:0]  start;
    logic          found;
    logic [W-1:0]  found_idx;
    logic          leave_run;

`ifdef CPU_THREAD_TIMESLICE_EN
    localparam int TS_W = $clog2(TIMESLICE) + 1;
    logic [TS_W-1:0] slice_cnt;
    assign leave_run = switch_req || (slice_cnt == TS_W'(TIMESLICE - 1));
`else
    assign leave_run = switch_req;
`endif

    // The previously chosen thread is searched last.
    assign start = (last == LAST_IDX) ? '0 : last + 1'b1;

    cpu_thread_switch_rr_select #(
        .N (N_THREADS),
        .W (W)
    ) u_rr (
        .ready (thread_ready),
        .start (start),
        .found (found),
        .index (found_idx)
    );

    // Scheduler FSM; every output is a flop so inputs never reach outputs combinationally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= CPU_TS_IDLE;
            thread_num  <= '0;
            last        <= LAST_IDX;
            load_en     <= 1'b0;
            save_en     <= 1'b0;
            run         <= 1'b0;
            switch_done <= 1'b0;
`ifdef CPU_THREAD_TIMESLICE_EN
            slice_cnt   <= '0;
`endif
        end else begin
            load_en     <= 1'b0;
            save_en     <= 1'b0;
            switch_done <= 1'b0;
            unique case (state)
                CPU_TS_IDLE: begin
                    run   <= 1'b0;
                    state <= CPU_TS_SELECT;
                end
                CPU_TS_SELECT: begin
                    run <= 1'b0;
                    if (found) begin
                        thread_num <= found_idx;
                        last       <= found_idx;
                        load_en    <= 1'b1;
                        state      <= CPU_TS_LOAD;
                    end
                end
                CPU_TS_LOAD: begin
                    run         <= 1'b1;
                    switch_done <= 1'b1;
                    state       <= CPU_TS_RUN;
`ifdef CPU_THREAD_TIMESLICE_EN
                    slice_cnt   <= '0;
`endif
                end
                CPU_TS_RUN: begin
                    if (leave_run) begin
                        run     <= 1'b0;
                        save_en <= 1'b1;
                        state   <= CPU_TS_SAVE;
                    end
`ifdef CPU_THREAD_TIMESLICE_EN
                    else begin
                        slice_cnt <= slice_cnt + 1'b1;
                    end
`endif
                end
                CPU_TS_SAVE: begin
                    run   <= 1'b0;
                    state <= CPU_TS_SELECT;
                end
                default: begin
                    run   <= 1'b0;
                    state <= CPU_TS_IDLE;
                end
            endcase
        end
    end

endmodule
